// File: rtl/dram_arbiter.sv
// DRAM arbiter: shares one DRAM between CPU accesses and CAS-before-RAS refresh,
// deferring refresh during accesses and tracking owed refreshes.
module dram_arbiter #(
  parameter int REFRESH_INTERVAL = 110,
  parameter int MAX_PENDING      = 4,
  parameter int TRP              = 1
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       ACC_REQ,
  input  logic       ACC_UDS,
  input  logic       ACC_LDS,
  output logic       RASn,
  output logic       UCASn,
  output logic       LCASn,
  output logic       ADDR_SEL,
  output logic       ACC_ACK,
  output logic [2:0] REF_PENDING,
  output logic       REF_OVERRUN,
  output logic [2:0] state_dbg
);

  localparam int              TW         = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]      PEND_MAX   = 3'(MAX_PENDING);
  localparam logic [1:0]      TRP_LAST   = 2'(TRP - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACC_ROW   = 3'd1,
    ACC_COL   = 3'd2,
    PRECHARGE = 3'd3,
    REF_CAS   = 3'd4,
    REF_RAS   = 3'd5
  } state_t;

  state_t        state_q, state_d, arb_state;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          ras_q, ras_d, ucas_q, ucas_d, lcas_q, lcas_d;
  logic          asel_q, asel_d, ack_q, ack_d;
  logic          tick, dec;

  // Handshake: ACC_REQ is held high for the whole bus cycle; ACC_ACK is high
  // only while the column strobes are active, and the access ends on the
  // edge that samples ACC_REQ low.
  always_comb begin
    arb_state = IDLE;
    if (pend_q == PEND_MAX)  arb_state = REF_CAS;
    else if (ACC_REQ)        arb_state = ACC_ROW;
    else if (pend_q != 3'd0) arb_state = REF_CAS;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = arb_state;
      ACC_ROW:   state_d = ACC_REQ ? ACC_COL : PRECHARGE;
      ACC_COL:   if (!ACC_REQ) state_d = PRECHARGE;
      PRECHARGE: if (cnt_q == TRP_LAST) state_d = arb_state;
      REF_CAS:   state_d = REF_RAS;
      REF_RAS:   if (cnt_q == 2'd1) state_d = PRECHARGE;
      default:   state_d = IDLE;
    endcase
    // cnt measures residency in the multi-cycle states, restarting on entry
    cnt_d = '0;
    if (state_d == state_q && (state_q == PRECHARGE || state_q == REF_RAS))
      cnt_d = cnt_q + 2'd1;
  end

  always_comb begin
    tick    = (timer_q == TIMER_LAST);
    timer_d = tick ? '0 : timer_q + TW'(1);
    dec     = (state_d == REF_CAS) && (state_q != REF_CAS);
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    // a tick and a refresh start on the same edge cancel out
    if (tick && !dec) begin
      if (pend_q == PEND_MAX) ovr_d  = 1'b1;
      else                    pend_d = pend_q + 3'd1;
    end else if (dec && !tick) begin
      pend_d = pend_q - 3'd1;
    end
  end

  always_comb begin
    ras_d  = 1'b1;
    ucas_d = 1'b1;
    lcas_d = 1'b1;
    asel_d = 1'b0;
    ack_d  = 1'b0;
    case (state_d)
      ACC_ROW: ras_d = 1'b0;
      ACC_COL: begin
        ras_d  = 1'b0;
        ucas_d = !ACC_UDS;
        lcas_d = !ACC_LDS;
        asel_d = 1'b1;
        ack_d  = 1'b1;
      end
      REF_CAS: begin
        ucas_d = 1'b0;
        lcas_d = 1'b0;
      end
      REF_RAS: begin
        ras_d  = 1'b0;
        ucas_d = 1'b0;
        lcas_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      ras_q   <= 1'b1;
      ucas_q  <= 1'b1;
      lcas_q  <= 1'b1;
      asel_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ras_q   <= ras_d;
      ucas_q  <= ucas_d;
      lcas_q  <= lcas_d;
      asel_q  <= asel_d;
      ack_q   <= ack_d;
    end
  end

  assign RASn        = ras_q;
  assign UCASn       = ucas_q;
  assign LCASn       = lcas_q;
  assign ADDR_SEL    = asel_q;
  assign ACC_ACK     = ack_q;
  assign REF_PENDING = pend_q;
  assign REF_OVERRUN = ovr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed cycle-by-cycle stimulus with hand-computed
// output vectors queued for a negedge monitor.
module tb_dram_arbiter;

  logic       clk, rst_n;
  logic       acc_req, acc_uds, acc_lds;
  logic       rasn, ucasn, lcasn, addr_sel, acc_ack, ref_overrun;
  logic [2:0] ref_pending, state_dbg;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  dram_arbiter dut (
    .CLK(clk), .RESETn(rst_n),
    .ACC_REQ(acc_req), .ACC_UDS(acc_uds), .ACC_LDS(acc_lds),
    .RASn(rasn), .UCASn(ucasn), .LCASn(lcasn),
    .ADDR_SEL(addr_sel), .ACC_ACK(acc_ack),
    .REF_PENDING(ref_pending), .REF_OVERRUN(ref_overrun),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  // vector layout: {RASn, UCASn, LCASn, ADDR_SEL, ACC_ACK, REF_PENDING, REF_OVERRUN}
  function automatic logic [8:0] e_idle(input logic [2:0] p, input logic ov);
    return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, p, ov};
  endfunction
  function automatic logic [8:0] e_row(input logic [2:0] p, input logic ov);
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, p, ov};
  endfunction
  function automatic logic [8:0] e_col(input logic u, input logic l, input logic [2:0] p, input logic ov);
    return {1'b0, !u, !l, 1'b1, 1'b1, p, ov};
  endfunction
  function automatic logic [8:0] e_rcas(input logic [2:0] p, input logic ov);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, p, ov};
  endfunction
  function automatic logic [8:0] e_rras(input logic [2:0] p, input logic ov);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p, ov};
  endfunction

  // driver tasks
  task automatic push(input logic [8:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input logic req, input logic u, input logic l,
                     input logic [8:0] e, input string nm);
    acc_req = req;
    acc_uds = u;
    acc_lds = l;
    @(posedge clk);
    #1;
    push(e, nm);
  endtask

  task automatic run(input int n, input logic req, input logic u, input logic l);
    acc_req = req;
    acc_uds = u;
    acc_lds = l;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    acc_req = 1'b0;
    acc_uds = 1'b0;
    acc_lds = 1'b0;
    push(e_idle(3'd0, 1'b0), "reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      push(e_idle(3'd0, 1'b0), "reset_hold");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] act, e;
    string      nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {rasn, ucasn, lcasn, addr_sel, acc_ack, ref_pending, ref_overrun};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got ras/ucas/lcas/asel/ack/pend/ovr=%b expected %b (state %0d, t=%0t)",
                 nm, act, e, state_dbg, $time);
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    acc_req = 1'b0;
    acc_uds = 1'b0;
    acc_lds = 1'b0;

    // idle access, back-to-back access, then aborted access
    reset_dut();
    cyc(1, 1, 0, e_row(0, 0),          "acc_row");
    cyc(1, 1, 0, e_col(1, 0, 0, 0),    "acc_col_upper");
    cyc(1, 1, 0, e_col(1, 0, 0, 0),    "acc_col_hold1");
    cyc(1, 1, 0, e_col(1, 0, 0, 0),    "acc_col_hold2");
    cyc(0, 1, 0, e_idle(0, 0),         "acc_precharge");
    cyc(1, 0, 1, e_row(0, 0),          "b2b_row");
    cyc(1, 0, 1, e_col(0, 1, 0, 0),    "b2b_col_lower");
    cyc(0, 0, 0, e_idle(0, 0),         "b2b_precharge");
    cyc(0, 0, 0, e_idle(0, 0),         "b2b_idle");
    cyc(1, 1, 1, e_row(0, 0),          "abort_row");
    cyc(0, 1, 1, e_idle(0, 0),         "abort_precharge_no_cas");
    cyc(0, 1, 1, e_idle(0, 0),         "abort_idle");

    // refresh with no traffic: first tick exactly 110 edges after reset
    reset_dut();
    run(108, 0, 0, 0);
    cyc(0, 0, 0, e_idle(0, 0),         "ref_before_tick");
    cyc(0, 0, 0, e_idle(1, 0),         "ref_tick_pending1");
    cyc(0, 0, 0, e_rcas(0, 0),         "ref_cas");
    cyc(0, 0, 0, e_rras(0, 0),         "ref_ras1");
    cyc(0, 0, 0, e_rras(0, 0),         "ref_ras2");
    cyc(0, 0, 0, e_idle(0, 0),         "ref_precharge");
    cyc(0, 0, 0, e_idle(0, 0),         "ref_idle");

    // deferral: long access, then four refreshes drain the backlog
    reset_dut();
    cyc(1, 1, 1, e_row(0, 0),          "defer_row");
    cyc(1, 1, 1, e_col(1, 1, 0, 0),    "defer_col");
    run(437, 1, 1, 1);
    cyc(1, 1, 1, e_col(1, 1, 4, 0),    "defer_pending4_no_refresh");
    run(59, 1, 1, 1);
    cyc(0, 1, 1, e_idle(4, 0),         "defer_precharge");
    for (int k = 0; k < 4; k++) begin
      logic [2:0] p;
      p = 3'(3 - k);
      cyc(0, 0, 0, e_rcas(p, 0),       "drain_cas");
      cyc(0, 0, 0, e_rras(p, 0),       "drain_ras1");
      cyc(0, 0, 0, e_rras(p, 0),       "drain_ras2");
      cyc(0, 0, 0, e_idle(p, 0),       "drain_precharge");
    end
    cyc(0, 0, 0, e_idle(0, 0),         "drain_idle");

    // saturation beats a waiting request; refresh is not pre-empted
    reset_dut();
    cyc(1, 1, 1, e_row(0, 0),          "sat_row");
    run(498, 1, 1, 1);
    cyc(0, 1, 1, e_idle(4, 0),         "sat_precharge");
    cyc(1, 1, 1, e_rcas(3, 0),         "sat_refresh_first");
    cyc(1, 1, 1, e_rras(3, 0),         "sat_ras1_req_held");
    cyc(1, 1, 1, e_rras(3, 0),         "sat_ras2_req_held");
    cyc(1, 1, 1, e_idle(3, 0),         "sat_ref_precharge");
    cyc(1, 1, 1, e_row(3, 0),          "sat_then_access_row");
    cyc(1, 1, 1, e_col(1, 1, 3, 0),    "sat_then_access_col");
    cyc(0, 1, 1, e_idle(3, 0),         "sat_access_precharge");

    // tick and refresh start on the same edge at saturation
    reset_dut();
    cyc(1, 0, 0, e_row(0, 0),          "same_row");
    run(546, 1, 0, 0);
    cyc(1, 0, 0, e_col(0, 0, 4, 0),    "same_col_no_strobes");
    cyc(0, 0, 0, e_idle(4, 0),         "same_precharge");
    cyc(0, 0, 0, e_rcas(4, 0),         "same_tick_and_dec");
    cyc(0, 0, 0, e_rras(4, 0),         "same_ras1");
    cyc(0, 0, 0, e_rras(4, 0),         "same_ras2");
    cyc(0, 0, 0, e_idle(4, 0),         "same_precharge2");
    cyc(0, 0, 0, e_rcas(3, 0),         "same_next_cas");

    // overrun on the 5th tick, sticky, cleared by reset during REF_RAS
    reset_dut();
    cyc(1, 1, 1, e_row(0, 0),          "ovr_row");
    run(547, 1, 1, 1);
    cyc(1, 1, 1, e_col(1, 1, 4, 0),    "ovr_before_5th_tick");
    cyc(1, 1, 1, e_col(1, 1, 4, 1),    "ovr_5th_tick");
    run(109, 1, 1, 1);
    cyc(1, 1, 1, e_col(1, 1, 4, 1),    "ovr_6th_tick_sticky");
    cyc(0, 1, 1, e_idle(4, 1),         "ovr_precharge");
    cyc(0, 0, 0, e_rcas(3, 1),         "ovr_ref_cas");
    cyc(0, 0, 0, e_rras(3, 1),         "ovr_ref_ras");
    reset_dut();
    cyc(0, 0, 0, e_idle(0, 0),         "post_reset_cleared");

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 110, meaning CLK cycles between refresh requests (15.6 us at 7.09 MHz).
REQ-002 SHALL have parameter MAX_PENDING, default 4, meaning the saturation limit of the deferred-refresh count (1..7).
REQ-003 SHALL have parameter TRP, default 1, meaning RAS precharge cycles (1..3).
REQ-004 CLK  in  1  system clock; all state updates on the rising edge.
REQ-005 RESETn  in  1  asynchronous, active-low reset.
REQ-006 ACC_REQ  in  1  decoded RAM access request, held high until the bus cycle ends.
REQ-007 ACC_UDS  in  1  active-high upper byte strobe.
REQ-008 ACC_LDS  in  1  active-high lower byte strobe.
REQ-009 RASn  out  1  DRAM row strobe, active low.
REQ-010 UCASn  out  1  DRAM upper column strobe, active low.
REQ-011 LCASn  out  1  DRAM lower column strobe, active low.
REQ-012 ADDR_SEL  out  1  address mux select: 0 = row, 1 = column.
REQ-013 ACC_ACK  out  1  high while column access is active.
REQ-014 REF_PENDING  out  3  count of owed refreshes.
REQ-015 REF_OVERRUN  out  1  sticky flag: a refresh was lost.

Function
REQ-016 All outputs SHALL be flops loaded from next-state values, with no combinational path from any input to any output.
REQ-017 States SHALL be IDLE, ACC_ROW, ACC_COL, PRECHARGE, REF_CAS and REF_RAS.
REQ-018 The refresh timer SHALL count 0..REFRESH_INTERVAL-1 every cycle, wrap to 0, and raise a tick on each wrap.
REQ-019 On a tick, REF_PENDING SHALL increment, saturating at MAX_PENDING.
REQ-020 A tick arriving while REF_PENDING==MAX_PENDING SHALL set REF_OVERRUN, which SHALL clear only on reset.
REQ-021 Entering REF_CAS SHALL decrement REF_PENDING.
REQ-022 A tick and a decrement on the same edge SHALL leave REF_PENDING unchanged, including at saturation, and SHALL NOT set REF_OVERRUN.
REQ-023 The arbitration decision, made in IDLE and on the last PRECHARGE cycle, SHALL use this priority:
  - first, REF_PENDING==MAX_PENDING -> REF_CAS;
  - else ACC_REQ -> ACC_ROW;
  - else REF_PENDING>0 -> REF_CAS;
  - else IDLE.
REQ-024 ACC_ROW SHALL last 1 cycle with RASn=0 and ADDR_SEL=0, then go to ACC_COL if ACC_REQ is still high, else PRECHARGE (abort, with no CAS asserted).
REQ-025 ACC_COL SHALL drive RASn=0, ADDR_SEL=1, ACC_ACK=1, UCASn=!ACC_UDS and LCASn=!ACC_LDS, and SHALL hold while ACC_REQ=1.
REQ-026 ACC_COL SHALL go to PRECHARGE on the edge where ACC_REQ=0 is sampled.
REQ-027 PRECHARGE SHALL hold RASn, UCASn and LCASn high and ACC_ACK=0 for exactly TRP cycles, then apply REQ-023.
REQ-028 REF_CAS SHALL last 1 cycle with UCASn=LCASn=0 and RASn=1 (CAS-before-RAS).
REQ-029 REF_RAS SHALL last 2 cycles with RASn=UCASn=LCASn=0, then go to PRECHARGE.
REQ-030 A refresh in progress SHALL NOT be pre-empted by ACC_REQ.
REQ-031 An access in progress SHALL NOT be pre-empted by a refresh, even at saturation.
REQ-032 RASn SHALL never go low without at least TRP high cycles immediately before it.
REQ-033 ADDR_SEL SHALL be 0 in every state except ACC_COL.

Reset
REQ-034 While RESETn=0, outputs SHALL immediately be RASn=UCASn=LCASn=1, ADDR_SEL=0, ACC_ACK=0, REF_PENDING=0 and REF_OVERRUN=0.
REQ-035 While RESETn=0, the state SHALL be IDLE and the timer SHALL be 0.
REQ-036 Reset asserted in any state, including mid-access or mid-refresh, SHALL abort immediately, with no strobe glitch low.
REQ-037 After RESETn deasserts, the first tick SHALL occur REFRESH_INTERVAL cycles later.

Verification
REQ-038 Idle access: ACC_REQ=1 with UDS=1, LDS=0 at edge 0, dropped before edge 5 -> expected response:
  - edge 1: RASn=0, ADDR_SEL=0;
  - edge 2: ADDR_SEL=1, UCASn=0, LCASn=1, ACC_ACK=1;
  - edge 5: all strobes high;
  - edge 6: back-to-back request may assert RASn.
REQ-039 Refresh alone: no requests for 110 cycles -> expected response:
  - REF_PENDING goes 1;
  - next edge REF_CAS (CAS low, RASn high), then 2 cycles all low, then 1 cycle all high;
  - REF_PENDING returns to 0.
REQ-040 Deferral: ACC_REQ held 500 cycles -> expected response:
  - REF_PENDING reaches 4 with no refresh during the access;
  - on release, PRECHARGE is followed by 4 refreshes if ACC_REQ stays low;
  - REF_OVERRUN=0 if the access ends before the 5th tick.
REQ-041 Saturation priority: REF_PENDING=4 and ACC_REQ=1 at the decision point -> refresh is taken first, then the access.
REQ-042 Overrun: ACC_REQ held for 5x110 cycles -> REF_OVERRUN=1 at the 5th tick, REF_PENDING stays 4, and the flag persists until reset.
REQ-043 Abort and reset:
  - ACC_REQ pulsed for 1 cycle -> ACC_ROW then PRECHARGE with UCASn/LCASn never low;
  - RESETn pulsed low during REF_RAS -> all strobes high asynchronously and REF_PENDING=0.
